// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the parametrised sequence detector.
package seq_det_pkg;

    localparam logic [4:0] DEF_PATTERN = 5'b11011;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // present_state must represent 0..pat_w inclusive
    function automatic int st_width(input int pat_w);
        return clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_len.sv
// Longest pattern prefix that matches the newest history bits.
module seq_prefix_len
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int ST_W  = st_width(PAT_W)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [PAT_W-1:0] pat_reg,
    input  logic [ST_W-1:0]  fill,
    output logic [ST_W-1:0]  present_state
);

    logic [PAT_W:1] hit;

    for (genvar k = 1; k <= PAT_W; k++) begin : g_len
        assign hit[k] = (fill >= ST_W'(k)) &&
                        (hist[k-1:0] == pat_reg[PAT_W-1:PAT_W-k]);
    end

    // later iterations override, so the longest hit wins
    always_comb begin
        present_state = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            if (hit[k]) present_state = ST_W'(k);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with reloadable pattern and saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              ST_W    = st_width(PAT_W)
) (
    input  logic             clk_pulse,
    input  logic             clear_n,
    input  logic             inp_1,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             count_clr,
    output logic             out,
    output logic [ST_W-1:0]  present_state,
    output logic [CNT_W-1:0] match_count
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d, hist_nx;
    logic [ST_W-1:0]  fill_q, fill_d, fill_nx;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match;

    always_comb begin
        hist_nx = {hist_q[PAT_W-2:0], inp_1};
        fill_nx = (fill_q == ST_W'(PAT_W)) ? fill_q : fill_q + ST_W'(1);
        match   = in_valid && !pat_load &&
                  (hist_nx == pat_q) && (fill_nx == ST_W'(PAT_W));
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        cnt_d  = cnt_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_nx;
            fill_d = (match && !OVERLAP) ? '0 : fill_nx;
            out_d  = match;
        end
        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_pulse or negedge clear_n) begin
        if (!clear_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    seq_prefix_len #(
        .PAT_W(PAT_W),
        .ST_W (ST_W)
    ) u_prefix (
        .hist         (hist_q),
        .pat_reg      (pat_q),
        .fill         (fill_q),
        .present_state(present_state)
    );

    assign out         = out_q;
    assign match_count = cnt_q;

endmodule
